// File: rtl/text_pixel_render_if.sv
// Font ROM bus between the text pixel renderer (master) and the synchronous glyph ROM (slave).
interface text_pixel_render_if;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    modport master (output font_addr, input font_data);
    modport slave  (input font_addr, output font_data);
endinterface

// File: rtl/text_pixel_render.sv
// Two-stage text overlay pixel pipeline: address the font ROM, then turn the glyph bit into RGB.
// Optional overlay blinking is enabled by defining TEXT_BLINK_EN.
module text_pixel_render #(
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        p_tick,
    input  logic                        video_on,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        text_on,
    input  logic [10:0]                 rom_addr,
    input  logic [2:0]                  bit_addr,
    input  logic                        blink,
    text_pixel_render_if.master         font_bus,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic [11:0]                 rgb
);

    logic [2:0] bit_addr_s1;
    logic       text_on_s1;
    logic       video_on_s1;
    logic       hsync_s1;
    logic       vsync_s1;
    logic       pix;
    logic       vis;

    // Stage 1 launches the ROM read; syncs idle high so a reset never emits a false pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            font_bus.font_addr <= '0;
            bit_addr_s1        <= '0;
            text_on_s1         <= 1'b0;
            video_on_s1        <= 1'b0;
            hsync_s1           <= 1'b1;
            vsync_s1           <= 1'b1;
        end else if (p_tick) begin
            font_bus.font_addr <= rom_addr;
            bit_addr_s1        <= bit_addr;
            text_on_s1         <= text_on;
            video_on_s1        <= video_on;
            hsync_s1           <= hsync_in;
            vsync_s1           <= vsync_in;
        end
    end

    // Column 0 is the leftmost pixel, which the ROM stores in the MSB.
    assign pix = font_bus.font_data[3'd7 - bit_addr_s1];

`ifdef TEXT_BLINK_EN
    logic [5:0] frame_cnt;
    logic       vsync_s1_d;

    // Count frames on the falling edge of the stage-1 vsync; bit 5 gives a 32-on/32-off cadence.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            vsync_s1_d <= 1'b1;
        end else begin
            vsync_s1_d <= vsync_s1;
            if (vsync_s1_d && !vsync_s1) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign vis = !(blink && frame_cnt[5]);
`else
    logic unused_blink;

    assign unused_blink = blink;
    assign vis          = 1'b1;
`endif

    // Stage 2 samples the ROM data, which has had at least one clk to settle since stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (p_tick) begin
            if (!video_on_s1) begin
                rgb <= 12'h000;
            end else if (text_on_s1 && vis && pix) begin
                rgb <= FG_RGB;
            end else begin
                rgb <= BG_RGB;
            end
            hsync_out <= hsync_s1;
            vsync_out <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_text_pixel_render.sv
// Directed self-checking bench for text_pixel_render with a small synchronous font ROM model.
// The blink frame checks expect hidden pixels only when TEXT_BLINK_EN is defined.
module tb_text_pixel_render;

    localparam logic [11:0] BG = 12'h135;
    localparam logic [11:0] FG = 12'hFFF;
`ifdef TEXT_BLINK_EN
    localparam logic [11:0] HIDDEN_RGB = BG;
`else
    localparam logic [11:0] HIDDEN_RGB = FG;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        text_on = 1'b0;
    logic [10:0] rom_addr = '0;
    logic [2:0]  bit_addr = '0;
    logic        blink = 1'b0;
    logic        hsync_out;
    logic        vsync_out;
    logic [11:0] rgb;

    int total = 0;
    int bad = 0;

    // Pixel table: address, column, text_on, video_on, hsync, vsync, expected rgb.
    logic [10:0] t_addr [8] = '{11'h460, 11'h460, 11'h7FF, 11'h7FF, 11'h123, 11'h123, 11'h460, 11'h000};
    logic [2:0]  t_bit  [8] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0};
    logic        t_text [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        t_vid  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        t_hs   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        t_vs   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] t_rgb  [8] = '{FG, BG, 12'h000, BG, FG, BG, FG, 12'h000};

    text_pixel_render_if rom_bus ();

    text_pixel_render #(
        .FG_RGB (FG),
        .BG_RGB (BG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .text_on   (text_on),
        .rom_addr  (rom_addr),
        .bit_addr  (bit_addr),
        .blink     (blink),
        .font_bus  (rom_bus),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .rgb       (rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romLookup(input logic [10:0] a);
        case (a)
            11'h460: return 8'h80;
            11'h7FF: return 8'hFF;
            11'h123: return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // One-clk-latency ROM, matching the real synchronous font ROM.
    always @(posedge clk) rom_bus.font_data <= romLookup(rom_bus.font_addr);

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one pixel with a single p_tick; returns on the falling edge after the tick edge.
    task automatic applyStimulus(input logic [10:0] a, input logic [2:0] b, input logic t,
                                 input logic v, input logic h, input logic vs);
        @(negedge clk);
        rom_addr = a;
        bit_addr = b;
        text_on  = t;
        video_on = v;
        hsync_in = h;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    task automatic vsyncPulses(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic checkFrame(input string tag, input logic [11:0] expected);
        applyStimulus(11'h7FF, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(11'h7FF, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput(tag, rgb, expected);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout observed=hang expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] reset and idle");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_rgb_%0d", i), rgb, 12'h000);
            checkOutput($sformatf("idle_hs_%0d", i), {11'd0, hsync_out}, 12'h001);
            checkOutput($sformatf("idle_vs_%0d", i), {11'd0, vsync_out}, 12'h001);
            checkOutput($sformatf("idle_addr_%0d", i), {1'b0, rom_bus.font_addr}, 12'h000);
            p_tick = (i % 2 == 0);
        end
        p_tick = 1'b0;

        $display("[TB] pixel table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(t_addr[i], t_bit[i], t_text[i], t_vid[i], t_hs[i], t_vs[i]);
            checkOutput($sformatf("font_addr_%0d", i), {1'b0, rom_bus.font_addr}, {1'b0, t_addr[i]});
            if (i > 0) begin
                checkOutput($sformatf("rgb_%0d", i - 1), rgb, t_rgb[i - 1]);
                checkOutput($sformatf("hsync_%0d", i - 1), {11'd0, hsync_out}, {11'd0, t_hs[i - 1]});
                checkOutput($sformatf("vsync_%0d", i - 1), {11'd0, vsync_out}, {11'd0, t_vs[i - 1]});
            end
            @(negedge clk);
            checkOutput($sformatf("addr_hold_%0d", i), {1'b0, rom_bus.font_addr}, {1'b0, t_addr[i]});
        end

        $display("[TB] reset mid-line");
        applyStimulus(11'h460, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(11'h460, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("pre_reset_rgb", rgb, FG);
        @(negedge clk);
        reset    = 1'b1;
        p_tick   = 1'b1;
        rom_addr = 11'h7FF;
        @(negedge clk);
        checkOutput("reset_rgb", rgb, 12'h000);
        checkOutput("reset_hs", {11'd0, hsync_out}, 12'h001);
        checkOutput("reset_vs", {11'd0, vsync_out}, 12'h001);
        checkOutput("reset_addr", {1'b0, rom_bus.font_addr}, 12'h000);
        reset  = 1'b0;
        p_tick = 1'b0;
        applyStimulus(11'h460, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("refill_tick1_rgb", rgb, 12'h000);
        applyStimulus(11'h460, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("refill_tick2_rgb", rgb, FG);

        $display("[TB] blink frames");
        blink = 1'b1;
        checkFrame("frame_0", FG);
        vsyncPulses(31);
        checkFrame("frame_31", FG);
        vsyncPulses(1);
        checkFrame("frame_32", HIDDEN_RGB);
        blink = 1'b0;
        checkFrame("frame_32_noblink", FG);
        blink = 1'b1;
        vsyncPulses(31);
        checkFrame("frame_63", HIDDEN_RGB);
        vsyncPulses(1);
        checkFrame("frame_64_wrap", FG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_pixel_render.md
# text_pixel_render

Consumer end of the text overlay path. Takes the glyph ROM address, bit index and overlay-enable produced by the text address generators, drives the synchronous font ROM, and turns the returned glyph row into an RGB pixel. Delays hsync/vsync/video_on to stay aligned with the ROM read latency, and feeds the VGA output stage.

## Interface
Parameters:
- `FG_RGB`, default 12'hFFF: colour of a set glyph bit.
- `BG_RGB`, default 12'h000: colour of a clear glyph bit, or of pixels outside the overlay.

Ports:
- `clk`  input  1: system clock.
- `reset`  input  1: synchronous, active-high reset.
- `p_tick`  input  1: pixel strobe; never asserted in two consecutive `clk` cycles.
- `video_on`  input  1: visible-area flag for the current pixel.
- `hsync_in`, `vsync_in`  input  1 each: raw sync for the current pixel; active low.
- `text_on`  input  1: overlay-enable for the current pixel.
- `rom_addr`  input  11: glyph ROM address, as {char[6:0], row[3:0]}.
- `bit_addr`  input  3: column index within the glyph row; 0 is leftmost.
- `blink`  input  1: request blinking of the overlay. Ignored without `TEXT_BLINK_EN`.
- `font_addr`  output  11: address to the synchronous font ROM.
- `font_data`  input  8: ROM data, valid 1 `clk` after `font_addr` changes.
- `hsync_out`, `vsync_out`  output  1 each: sync, delayed 2 `p_tick`.
- `rgb`  output  12: pixel colour, delayed 2 `p_tick`.

## Operation
- **Stage 1** (on `p_tick`):
  - `font_addr` <= `rom_addr`.
  - Register `bit_addr`, `text_on`, `video_on`, `hsync_in` and `vsync_in` into stage-1 registers.
- **ROM**: `font_data` settles 1 `clk` after stage 1 updates. The next `p_tick` always comes at least 2 `clk` later, so the data is valid when stage 2 samples it.
- **Stage 2** (on `p_tick`):
  - Pixel bit: `pix = font_data[7 - bit_addr_s1]`.
  - `rgb` <= `!video_on_s1` ? 12'h000 : (`text_on_s1` && `vis` && `pix`) ? `FG_RGB` : `BG_RGB`.
  - `hsync_out` / `vsync_out` <= the stage-1 sync values.
- **`vis`**: constant 1 without blink; with blink, see Configuration.
- With no `p_tick`, every register holds its value.
- **Reset values**: `font_addr`=0, `rgb`=0, `hsync_out`=1, `vsync_out`=1, all stage-1 flags 0 except syncs at 1, frame counter 0.
- **Reset mid-line**: outputs go to reset values on the next `clk`. The pipeline refills after 2 `p_tick`. No stale pixel data leaks out after reset.

## Timing
- Latency: input pixel N appears on `rgb` / `hsync_out` / `vsync_out` on the 2nd `p_tick` after it is presented. Sync and colour are always mutually aligned.
- `font_addr` changes only on a `clk` edge where `p_tick`=1.
- A `p_tick` coincident with `reset`: reset wins.
- `text_on`=1 with `video_on`=0 gives black (`video_on` has priority).
- `bit_addr` is used raw: 3'd7 selects `font_data[0]`, and 3'd0 selects `font_data[7]`. There is no wrap logic.

## Configuration
- Macro: `TEXT_BLINK_EN`.
- **Defined**:
  - A 6-bit frame counter increments on each falling edge of the stage-1 vsync, detected via a registered copy. It wraps 63 -> 0.
  - `vis` = !(`blink` && `frame_cnt[5]`): 32 frames shown, 32 frames hidden.
  - Hidden overlay pixels render `BG_RGB`.
- **Undefined**: no counter, `vis` = 1, and the `blink` port is present but unused.

## Test plan
- Reset then idle: `rgb`=0, `hsync_out`=1, `vsync_out`=1, `font_addr`=0 held for 10 `clk` with `p_tick` toggling every 2 `clk`.
- `rom_addr`=11'h460, `bit_addr`=0, `text_on`=1, `video_on`=1, ROM model returns 8'h80 -> `rgb`=12'hFFF on the 2nd `p_tick`. With `bit_addr`=1 -> 12'h000.
- `video_on`=0, `text_on`=1, `font_data`=8'hFF -> `rgb`=12'h000. `video_on`=1, `text_on`=0 -> `BG_RGB`.
- `hsync_in` low for exactly one `p_tick` -> `hsync_out` low for exactly one `p_tick`, 2 ticks later, coincident with that pixel's `rgb`.
- `reset` asserted mid-line with `rgb`=FFF -> next `clk` gives `rgb`=0 and syncs=1. The first valid pixel after reset appears 2 `p_tick` later.
- With `TEXT_BLINK_EN` and `blink`=1, `font_data`=8'hFF: frames 0–31 give FFF, 32–63 give 000, frame 64 gives FFF again (wrap). With `blink`=0, always FFF.
